mp64_bus_arbiter: RTL and testbench
===================================

Name: mp64_bus_arbiter

Overview:
- Round-robin arbiter that shares one memory bus slave port between N_PORTS mp64_cpu bus masters in the multi-core build.
- Sits between the per-core bus_* ports and the memory/interconnect slave.
- One outstanding transaction at a time.
- Request payload is latched at grant, so masters and slave are fully decoupled.

Parameters:
- N_PORTS, 4, number of master ports (2..16).
- PTR_W, $clog2(N_PORTS), width of the grant index.
- TIMEOUT_CYCLES, 256, slave response timeout (used only with MP64_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_valid  in  N_PORTS  per-master request; held with payload stable until that master's m_ready.
- m_addr  in  64*N_PORTS  flattened addresses; master k at [64k+63:64k].
- m_wdata  in  64*N_PORTS  flattened write data.
- m_wen  in  N_PORTS  write enable.
- m_size  in  2*N_PORTS  BUS_BYTE/HALF/WORD/DWORD.
- m_rdata  out  64  registered read data, shared by all masters; valid while the addressed m_ready is high.
- m_ready  out  N_PORTS  one-cycle completion pulse; at most one bit set.
- s_valid  out  1  one-cycle request pulse to the slave.
- s_addr  out  64  latched address.
- s_wdata  out  64  latched write data.
- s_wen  out  1  latched write enable.
- s_size  out  2  latched size.
- s_rdata  in  64  slave read data, valid with s_ready.
- s_ready  in  1  slave completion pulse.
- grant_id  out  PTR_W  index of the current or last granted master.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  one-cycle pulse when a transaction times out; constant 0 when the feature is off.

Behaviour:
- Reset (async, rst_n low): go to IDLE and drop any in-flight transaction. All outputs are 0. rr_ptr=0, timeout counter=0.
- FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE:
  - Search m_valid starting at rr_ptr, wrapping modulo N_PORTS; the first set bit wins.
  - On a winner g: latch m_addr/m_wdata/m_wen/m_size[g] into s_*, set grant_id=g, rr_ptr=(g+1) mod N_PORTS, go to REQ.
  - With no requests: stay in IDLE; rr_ptr unchanged.
- REQ:
  - s_valid=1 for exactly this cycle.
  - If s_ready=1 (zero-latency slave): capture s_rdata, go to RESP. Otherwise go to WAIT.
- WAIT:
  - s_valid=0.
  - On s_ready: capture s_rdata into m_rdata (writes capture too), go to RESP.
- RESP:
  - m_ready[grant_id]=1 for one cycle; m_rdata holds the captured value.
  - Always go to IDLE. m_valid is not sampled in RESP.
- Latency: with a 1-cycle slave, m_valid seen in cycle 0 gives REQ in cycle 1, s_ready in cycle 2, m_ready in cycle 3. Back-to-back transactions take 4 cycles each.
- s_ready seen in IDLE or RESP is ignored (spurious or late pulse).
- m_valid dropping mid-transaction has no effect; the latched transaction completes and m_ready still pulses.
- Fairness: a master that continuously requests waits at most N_PORTS-1 transactions.
- s_* payload is held stable from REQ until the next grant.

Optional Feature:
- Macro: MP64_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no s_ready: set m_rdata=64'hFFFF_FFFF_FFFF_FFFF, pulse timeout with the RESP transition, go to RESP.
  - A late s_ready is ignored.
  - s_ready arriving in the same cycle as the terminal count wins: normal completion, no timeout.
- Undefined: no counter; WAIT waits indefinitely; timeout is tied to 0.

Decomposition:
- mp64_defs.vh gains ARB_IDLE/ARB_REQ/ARB_WAIT/ARB_RESP (2-bit) and ARB_TIMEOUT_DATA. BUS_* size codes already live there.
- Sub-module mp64_rr_pick: combinational round-robin first-one finder (req vector, ptr) -> (found, idx). It is unit-tested separately.

Test Plan:
- Single master 0, read DWORD at 0x100 with mem=0x0807060504030201, 1-cycle slave -> s_valid pulse in cycle 1; m_ready[0] in cycle 3; m_rdata=0x0807060504030201.
- Masters 0..3 all holding m_valid from reset -> grant order 0,1,2,3,0; each m_ready is a single pulse; never two m_ready bits high.
- Master 2 writes WORD 0xDEADBEEF to 0x40, then master 1 reads WORD at 0x40 -> m_rdata=0x00000000DEADBEEF. Only one s_valid pulse per transaction.
- Slave delays s_ready by 10 cycles; master changes m_addr after grant -> s_addr stays at the latched value; m_ready arrives 12 cycles after REQ-1.
- rst_n pulsed low during WAIT -> all outputs 0 immediately; the later s_ready is ignored; the next grant starts from port 0.
- (MP64_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never responds -> timeout pulse and m_ready with m_rdata=all-ones; FSM returns to IDLE; a late s_ready produces no extra m_ready.

Source files
------------

// File: rtl/mp64_bus_arbiter_pkg.sv
// rtl/mp64_bus_arbiter_pkg.sv - bus size codes, arbiter state encoding and timeout fill value
package mp64_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      BUS_BYTE  = 2'd0,
      BUS_HALF  = 2'd1,
      BUS_WORD  = 2'd2,
      BUS_DWORD = 2'd3
   } bus_size_e;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2,
      ARB_RESP = 2'd3
   } arb_state_e;

   localparam logic [63:0] ARB_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mp64_rr_pick.sv
// rtl/mp64_rr_pick.sv - combinational round-robin first-one finder starting at i_ptr
module mp64_rr_pick
   import mp64_bus_arbiter_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int PTR_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic               o_found,
   output logic [PTR_W-1:0]   o_idx
);

   int               w_sum;
   logic [PTR_W-1:0] w_cand;

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_sum   = 0;
      w_cand  = '0;
      // Scan farthest offset first so the request nearest i_ptr is the last write.
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         w_sum  = (int'(i_ptr) + i) % N_PORTS;
         w_cand = PTR_W'(w_sum);
         if (i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/mp64_bus_arbiter.sv
// rtl/mp64_bus_arbiter.sv - round-robin single-outstanding bus arbiter; MP64_ARB_TIMEOUT_EN adds slave timeout
module mp64_bus_arbiter
   import mp64_bus_arbiter_pkg::*;
#(
   parameter int N_PORTS        = 4,
   parameter int PTR_W          = $clog2(N_PORTS),
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_PORTS-1:0]    m_valid,
   input  logic [64*N_PORTS-1:0] m_addr,
   input  logic [64*N_PORTS-1:0] m_wdata,
   input  logic [N_PORTS-1:0]    m_wen,
   input  logic [2*N_PORTS-1:0]  m_size,
   output logic [63:0]           m_rdata,
   output logic [N_PORTS-1:0]    m_ready,
   output logic                  s_valid,
   output logic [63:0]           s_addr,
   output logic [63:0]           s_wdata,
   output logic                  s_wen,
   output logic [1:0]            s_size,
   input  logic [63:0]           s_rdata,
   input  logic                  s_ready,
   output logic [PTR_W-1:0]      grant_id,
   output logic                  busy,
   output logic                  timeout
);

   arb_state_e         r_state;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   r_grant;
   logic [N_PORTS-1:0] r_m_ready;
   logic [63:0]        r_m_rdata;
   logic               r_s_valid;
   logic [63:0]        r_s_addr;
   logic [63:0]        r_s_wdata;
   logic               r_s_wen;
   logic [1:0]         r_s_size;
   logic               r_busy;

   logic               w_found;
   logic [PTR_W-1:0]   w_idx;
   logic [PTR_W-1:0]   w_next_ptr;
   logic [N_PORTS-1:0] w_grant_oh;

`ifdef MP64_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             w_expire;

   assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout  = r_timeout;
`else
   assign timeout = 1'b0;
   // TIMEOUT_CYCLES has no effect unless the timeout is compiled in.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
`endif

   mp64_rr_pick #(
      .N_PORTS (N_PORTS),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .i_req   (m_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   assign w_next_ptr = (w_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_idx + 1'b1;
   assign w_grant_oh = N_PORTS'(1) << r_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ARB_IDLE;
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_m_ready <= '0;
         r_m_rdata <= '0;
         r_s_valid <= 1'b0;
         r_s_addr  <= '0;
         r_s_wdata <= '0;
         r_s_wen   <= 1'b0;
         r_s_size  <= '0;
         r_busy    <= 1'b0;
`ifdef MP64_ARB_TIMEOUT_EN
         r_cnt     <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_found) begin
                  r_s_addr  <= m_addr[w_idx*64 +: 64];
                  r_s_wdata <= m_wdata[w_idx*64 +: 64];
                  r_s_wen   <= m_wen[w_idx];
                  r_s_size  <= m_size[w_idx*2 +: 2];
                  r_grant   <= w_idx;
                  r_rr_ptr  <= w_next_ptr;
                  r_s_valid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ARB_REQ;
               end
            end
            ARB_REQ: begin
               r_s_valid <= 1'b0;
               if (s_ready) begin
                  r_m_rdata <= s_rdata;
                  r_m_ready <= w_grant_oh;
                  r_state   <= ARB_RESP;
               end else begin
                  r_state   <= ARB_WAIT;
`ifdef MP64_ARB_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end
            end
            ARB_WAIT: begin
               // A response on the terminal-count cycle still completes normally.
               if (s_ready) begin
                  r_m_rdata <= s_rdata;
                  r_m_ready <= w_grant_oh;
                  r_state   <= ARB_RESP;
               end
`ifdef MP64_ARB_TIMEOUT_EN
               else if (w_expire) begin
                  r_m_rdata <= ARB_TIMEOUT_DATA;
                  r_m_ready <= w_grant_oh;
                  r_timeout <= 1'b1;
                  r_state   <= ARB_RESP;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
               end
`endif
            end
            ARB_RESP: begin
               r_m_ready <= '0;
               r_busy    <= 1'b0;
               r_state   <= ARB_IDLE;
`ifdef MP64_ARB_TIMEOUT_EN
               r_timeout <= 1'b0;
`endif
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign m_rdata  = r_m_rdata;
   assign m_ready  = r_m_ready;
   assign s_valid  = r_s_valid;
   assign s_addr   = r_s_addr;
   assign s_wdata  = r_s_wdata;
   assign s_wen    = r_s_wen;
   assign s_size   = r_s_size;
   assign grant_id = r_grant;
   assign busy     = r_busy;

endmodule

// File: tb/tb_mp64_bus_arbiter.sv
// tb/tb_mp64_bus_arbiter.sv - scoreboard bench for mp64_bus_arbiter with a behavioural memory slave
module tb_mp64_bus_arbiter;
   import mp64_bus_arbiter_pkg::*;

   localparam int          N       = 4;
   localparam int          PW      = 2;
   localparam int          TO      = 8;
   localparam logic [63:0] WR_RESP = 64'h0000_0000_0000_A5A5;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    m_valid = '0;
   logic [64*N-1:0] m_addr  = '0;
   logic [64*N-1:0] m_wdata = '0;
   logic [N-1:0]    m_wen   = '0;
   logic [2*N-1:0]  m_size  = '0;
   logic [63:0]     m_rdata;
   logic [N-1:0]    m_ready;
   logic            s_valid;
   logic [63:0]     s_addr;
   logic [63:0]     s_wdata;
   logic            s_wen;
   logic [1:0]      s_size;
   logic [63:0]     s_rdata = '0;
   logic            s_ready = 1'b0;
   logic [PW-1:0]   grant_id;
   logic            busy;
   logic            timeout;

   mp64_bus_arbiter #(
      .N_PORTS        (N),
      .PTR_W          (PW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_valid  (m_valid),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wen    (m_wen),
      .m_size   (m_size),
      .m_rdata  (m_rdata),
      .m_ready  (m_ready),
      .s_valid  (s_valid),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wen    (s_wen),
      .s_size   (s_size),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [63:0] data;
      logic        to;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   sv_cnt = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Memory slave: slave_delay negedges after s_valid it answers; -1 never answers.
   logic [63:0] mem [logic [63:0]];
   int          slave_delay = 1;
   bit          spur = 1'b0;
   logic [63:0] sl_addr, sl_wdata;
   logic        sl_wen;
   logic [1:0]  sl_size;

   function automatic logic [63:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   initial forever begin
      @(negedge clk);
      s_ready = spur;
      spur    = 1'b0;
      if (s_valid && slave_delay >= 0) begin
         sl_addr  = s_addr;
         sl_wdata = s_wdata;
         sl_wen   = s_wen;
         sl_size  = s_size;
         repeat (slave_delay) @(negedge clk);
         if (sl_wen) begin
            mem[sl_addr] = sl_wdata & size_mask(sl_size);
            s_rdata      = WR_RESP;
         end else begin
            s_rdata = (mem.exists(sl_addr) ? mem[sl_addr] : 64'h0) & size_mask(sl_size);
         end
         s_ready = 1'b1;
      end
   end

   // Monitor: every completion pulse pops one expected response.
   initial forever begin
      @(negedge clk);
      if (s_valid) sv_cnt++;
      if (m_ready != '0) begin
         check("ready_onehot", 64'($onehot(m_ready)), 64'd1);
         if (sb.size() == 0) begin
            check("unexpected_ready", 64'(m_ready), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("ready_port", 64'(m_ready), 64'(N'(1) << mon_e.port));
            check("rdata", m_rdata, mon_e.data);
            check("timeout_flag", 64'(timeout), 64'(mon_e.to));
         end
      end
   end

   task automatic set_req(input int p, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic wen, input logic [1:0] sz);
      m_addr[p*64 +: 64]  = addr;
      m_wdata[p*64 +: 64] = wdata;
      m_wen[p]            = wen;
      m_size[p*2 +: 2]    = sz;
      m_valid[p]          = 1'b1;
   endtask

   task automatic wait_svalid(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (s_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("svalid_wait", 64'd0, 64'd1);
   endtask

   task automatic wait_ready(input int p, input int budget, output int n);
      n = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (m_ready[p]) begin
            n = i;
            break;
         end
      end
      if (n == 0) check($sformatf("ready%0d_wait", p), 64'd0, 64'd1);
   endtask

   int n;
   int sv0;
   int pulses;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation ran past 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mem[64'h100] = 64'h0807_0605_0403_0201;
      for (int k = 0; k < N; k++) mem[64'h200 + 64'(8*k)] = 64'h1111_1111_1111_1111 * 64'(k + 1);
      mem[64'h300] = 64'h0123_4567_89AB_CDEF;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_m_ready", 64'(m_ready), 64'd0);
      check("rst_s_valid", 64'(s_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_grant", 64'(grant_id), 64'd0);
      check("rst_m_rdata", m_rdata, 64'd0);
      check("rst_s_addr", s_addr, 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single DWORD read, 1-cycle slave
      sb.push_back('{0, 64'h0807_0605_0403_0201, 1'b0});
      sv0 = sv_cnt;
      set_req(0, 64'h100, 64'h0, 1'b0, BUS_DWORD);
      wait_svalid(10);
      check("t1_s_addr", s_addr, 64'h100);
      check("t1_grant", 64'(grant_id), 64'd0);
      check("t1_busy", 64'(busy), 64'd1);
      wait_ready(0, 20, n);
      m_valid[0] = 1'b0;
      check("t1_latency", 64'(n), 64'd2);
      repeat (2) @(negedge clk);
      check("t1_svalid_pulses", 64'(sv_cnt - sv0), 64'd1);

      // All four masters requesting from reset: grants 0,1,2,3,0
      for (int k = 0; k < N; k++) set_req(k, 64'h200 + 64'(8*k), 64'h0, 1'b0, BUS_DWORD);
      rst_n = 1'b0;
      @(negedge clk);
      for (int k = 0; k < N; k++) sb.push_back('{k, 64'h1111_1111_1111_1111 * 64'(k + 1), 1'b0});
      sb.push_back('{0, 64'h1111_1111_1111_1111, 1'b0});
      sv0    = sv_cnt;
      pulses = 0;
      rst_n  = 1'b1;
      for (int i = 0; i < 60 && pulses < 5; i++) begin
         @(negedge clk);
         if (m_ready != '0) pulses++;
      end
      m_valid = '0;
      check("t2_pulses", 64'(pulses), 64'd5);
      repeat (2) @(negedge clk);
      check("t2_svalid_pulses", 64'(sv_cnt - sv0), 64'd5);

      // Master 2 writes WORD, master 1 reads it back
      sv0 = sv_cnt;
      sb.push_back('{2, WR_RESP, 1'b0});
      set_req(2, 64'h40, 64'hCAFE_F00D_DEAD_BEEF, 1'b1, BUS_WORD);
      wait_svalid(10);
      check("t3_s_wen", 64'(s_wen), 64'd1);
      check("t3_s_size", 64'(s_size), 64'(BUS_WORD));
      check("t3_s_wdata", s_wdata, 64'hCAFE_F00D_DEAD_BEEF);
      wait_ready(2, 20, n);
      m_valid[2] = 1'b0;
      sb.push_back('{1, 64'h0000_0000_DEAD_BEEF, 1'b0});
      set_req(1, 64'h40, 64'h0, 1'b0, BUS_WORD);
      wait_ready(1, 20, n);
      m_valid[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_svalid_pulses", 64'(sv_cnt - sv0), 64'd2);

      // Slow slave, master changes its address after grant
      slave_delay = 10;
      sb.push_back('{3, 64'h0123_4567_89AB_CDEF, 1'b0});
      set_req(3, 64'h300, 64'h0, 1'b0, BUS_DWORD);
      wait_svalid(10);
      m_addr[3*64 +: 64] = 64'h999;
      wait_ready(3, 40, n);
      m_valid[3] = 1'b0;
      check("t4_latency", 64'(n), 64'd11);
      check("t4_s_addr_held", s_addr, 64'h300);

      // Reset during WAIT: outputs clear at once, late s_ready ignored, pointer restarts at 0
      set_req(1, 64'h500, 64'h0, 1'b0, BUS_DWORD);
      wait_svalid(10);
      repeat (3) @(negedge clk);
      check("t5_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_grant", 64'(grant_id), 64'd0);
      check("t5_s_addr", s_addr, 64'd0);
      check("t5_m_rdata", m_rdata, 64'd0);
      m_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("t5_idle_after_late", 64'(busy), 64'd0);
      slave_delay = 1;
      sb.push_back('{0, 64'h0807_0605_0403_0201, 1'b0});
      sb.push_back('{2, 64'h3333_3333_3333_3333, 1'b0});
      set_req(0, 64'h100, 64'h0, 1'b0, BUS_DWORD);
      set_req(2, 64'h210, 64'h0, 1'b0, BUS_DWORD);
      wait_ready(0, 20, n);
      m_valid[0] = 1'b0;
      wait_ready(2, 20, n);
      m_valid[2] = 1'b0;
      repeat (2) @(negedge clk);

`ifdef MP64_ARB_TIMEOUT_EN
      // Silent slave: timeout completes with all-ones, late s_ready gives nothing
      slave_delay = -1;
      sb.push_back('{0, ARB_TIMEOUT_DATA, 1'b1});
      set_req(0, 64'h100, 64'h0, 1'b0, BUS_DWORD);
      wait_svalid(10);
      wait_ready(0, 40, n);
      m_valid[0] = 1'b0;
      check("t6_latency", 64'(n), 64'd9);
      repeat (2) @(negedge clk);
      check("t6_idle", 64'(busy), 64'd0);
      spur = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_idle_after_late", 64'(busy), 64'd0);
      slave_delay = 1;
`endif

      repeat (5) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
